// File: rtl/axi_dbg_periph.sv
// AXI4-lite style debug slave: buffered UART console, cycle timer, pass/fail control and scratch.
// Define DBG_WATCHDOG_EN to build in a watchdog that forces fail after WDOG_CYCLES.
module axi_dbg_periph #(
  parameter int          IDW         = 4,
  parameter int          DW          = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          UART_DEPTH  = 8,
  parameter int          UART_DIV    = 1,
  parameter int          WDOG_CYCLES = 1000000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [IDW-1:0]  AWID,
  input  logic [31:0]     AWADDR,
  input  logic            AWVALID,
  output logic            AWREADY,
  input  logic [DW-1:0]   WDATA,
  input  logic [DW/8-1:0] WSTRB,
  input  logic            WVALID,
  output logic            WREADY,
  output logic [IDW-1:0]  BID,
  output logic [1:0]      BRESP,
  output logic            BVALID,
  input  logic            BREADY,
  input  logic [IDW-1:0]  ARID,
  input  logic [31:0]     ARADDR,
  input  logic            ARVALID,
  output logic            ARREADY,
  output logic [IDW-1:0]  RID,
  output logic [DW-1:0]   RDATA,
  output logic [1:0]      RRESP,
  output logic            RVALID,
  input  logic            RREADY,
  output logic            success,
  output logic            fail,
  output logic [7:0]      exit_code
);
  localparam int SW   = DW / 8;
  localparam int PW   = (UART_DEPTH > 1) ? $clog2(UART_DEPTH) : 1;
  localparam int LW   = PW + 1;
  localparam int DIVW = (UART_DIV > 1) ? $clog2(UART_DIV) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Offset in 8-byte words; upper bits must be zero to land inside the 64-byte window.
  function automatic logic is_mapped(input logic [28:0] q);
    return (q[28:3] == '0) && ((q[2:0] <= 3'd4) || (DW == 32 && q[2:0] == 3'd5));
  endfunction

  logic           aw_held, w_held;
  logic [IDW-1:0] aw_id;
  logic [31:0]    aw_addr;
  logic [DW-1:0]  w_data;
  logic [SW-1:0]  w_strb;
  logic [31:0]    wr_off, rd_off;
  logic           wr_map, rd_map, push_req, uart_blk, commit, push;
  logic           ctrl_wr, set_success, tmr_wr, scr_wr, ar_acc, wdog_hit;
  logic [7:0]     fifo_mem [UART_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  fifo_lvl;
  logic [DIVW-1:0] div_q;
  logic           fifo_full, fifo_pop;
  logic           tmr_run;
  logic [63:0]    tmr_cnt;
  logic [DW-1:0]  scratch;
  logic [63:0]    rd_word;
  logic           unused_off_lsbs;

  assign wr_off          = aw_addr - BASE_ADDR;
  assign rd_off          = ARADDR - BASE_ADDR;
  assign unused_off_lsbs = ^{wr_off[2:0], rd_off[2:0]};
  assign wr_map          = is_mapped(wr_off[31:3]);
  assign rd_map          = is_mapped(rd_off[31:3]);

  assign AWREADY = ~aw_held;
  assign WREADY  = ~w_held;
  assign ARREADY = ~RVALID | RREADY;
  assign ar_acc  = ARVALID & ARREADY;

  assign fifo_full = (fifo_lvl == LW'(UART_DEPTH));
  assign fifo_pop  = (fifo_lvl != '0) && (div_q == DIVW'(UART_DIV - 1));

  // A full FIFO stalls a console commit unless a drain frees the slot this same cycle.
  assign push_req = wr_map && (wr_off[5:3] == 3'd0) && w_strb[0];
  assign uart_blk = push_req && fifo_full && !fifo_pop;
  assign commit   = aw_held && w_held && (!BVALID || BREADY) && !uart_blk;
  assign push     = commit && push_req;

  assign tmr_wr      = commit && wr_map && (wr_off[5:3] == 3'd1);
  assign scr_wr      = commit && wr_map && (wr_off[5:3] == 3'd3);
  assign ctrl_wr     = commit && wr_map && (wr_off[5:3] == 3'd2) && !success && !fail &&
                       (w_data != '0) && !wdog_hit;
  assign set_success = ctrl_wr && (w_data == DW'(1));

`ifdef DBG_WATCHDOG_EN
  logic [31:0] wdog_cnt;
  assign wdog_hit = (wdog_cnt == 32'(WDOG_CYCLES)) && !success && !fail;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                 wdog_cnt <= '0;
    else if (wdog_cnt != 32'(WDOG_CYCLES))   wdog_cnt <= wdog_cnt + 32'd1;
  end
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0);
  assign wdog_hit    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (AWVALID && AWREADY) begin
      aw_id   <= AWID;
      aw_addr <= AWADDR;
    end
    if (WVALID && WREADY) begin
      w_data <= WDATA;
      w_strb <= WSTRB;
    end
    if (push) fifo_mem[wr_ptr] <= w_data[7:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= RESP_OKAY;
    end else begin
      if (AWVALID && AWREADY) aw_held <= 1'b1;
      else if (commit)        aw_held <= 1'b0;
      if (WVALID && WREADY)   w_held  <= 1'b1;
      else if (commit)        w_held  <= 1'b0;
      if (commit) begin
        BVALID <= 1'b1;
        BID    <= aw_id;
        BRESP  <= wr_map ? RESP_OKAY : RESP_DECERR;
      end else if (BREADY) begin
        BVALID <= 1'b0;
      end
    end
  end

  // Console FIFO and drain divider; the divider only runs while bytes are waiting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_lvl <= '0;
      div_q    <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, fifo_pop})
        2'b10:   fifo_lvl <= fifo_lvl + LW'(1);
        2'b01:   fifo_lvl <= fifo_lvl - LW'(1);
        default: fifo_lvl <= fifo_lvl;
      endcase
      if (fifo_lvl == '0 || div_q == DIVW'(UART_DIV - 1)) div_q <= '0;
      else                                                div_q <= div_q + DIVW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmr_run   <= 1'b0;
      tmr_cnt   <= '0;
      success   <= 1'b0;
      fail      <= 1'b0;
      exit_code <= '0;
      scratch   <= '0;
    end else begin
      if (tmr_wr && w_data == DW'(1))      tmr_run <= 1'b1;
      else if (tmr_wr && w_data == '0)     tmr_run <= 1'b0;
      if (tmr_wr && w_data == DW'(2))      tmr_cnt <= '0;
      else if (tmr_run)                    tmr_cnt <= tmr_cnt + 64'd1;
      if (wdog_hit) begin
        fail      <= 1'b1;
        exit_code <= 8'hFF;
      end else if (set_success) begin
        success <= 1'b1;
      end else if (ctrl_wr) begin
        fail      <= 1'b1;
        exit_code <= w_data[7:0];
      end
      for (int b = 0; b < SW; b++)
        if (scr_wr && w_strb[b]) scratch[b*8 +: 8] <= w_data[b*8 +: 8];
    end
  end

  always_comb begin
    rd_word = '0;
    case (rd_off[5:3])
      3'd1:    rd_word = tmr_cnt;
      3'd2:    rd_word = 64'({exit_code, fail, success});
      3'd3:    rd_word[DW-1:0] = scratch;
      3'd4:    rd_word = 64'({fifo_lvl, fifo_full, fail, success, tmr_run});
      3'd5:    rd_word = {32'b0, tmr_cnt[63:32]};
      default: rd_word = '0;
    endcase
  end

  // Read data is captured at AR acceptance and held until RREADY.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RVALID <= 1'b0;
      RID    <= '0;
      RDATA  <= '0;
      RRESP  <= RESP_OKAY;
    end else if (ar_acc) begin
      RVALID <= 1'b1;
      RID    <= ARID;
      RDATA  <= rd_map ? rd_word[DW-1:0] : '0;
      RRESP  <= rd_map ? RESP_OKAY : RESP_DECERR;
    end else if (RREADY) begin
      RVALID <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (!RST) begin
      if (fifo_pop)    $write("%c", fifo_mem[rd_ptr]);
      if (set_success) $display("axi_dbg_periph: success, cycle count %0d", tmr_cnt);
`ifdef DBG_WATCHDOG_EN
      if (wdog_hit)    $display("watchdog timeout");
`endif
    end
  end
`endif

endmodule

// File: tb/tb_axi_dbg_periph.sv
// Directed testbench for axi_dbg_periph: bus handshakes, console FIFO, timer, ctrl, scratch, errors.
module tb_axi_dbg_periph;
  localparam logic [31:0] BASE   = 32'h2000_0000;
  localparam logic [31:0] A_UART = BASE;
  localparam logic [31:0] A_TMR  = BASE + 32'h08;
  localparam logic [31:0] A_CTRL = BASE + 32'h10;
  localparam logic [31:0] A_SCR  = BASE + 32'h18;
  localparam logic [31:0] A_STAT = BASE + 32'h20;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  AWID = '0, BID, ARID = '0, RID;
  logic [31:0] AWADDR = '0, ARADDR = '0;
  logic        AWVALID = 1'b0, AWREADY, WVALID = 1'b0, WREADY, BVALID, BREADY = 1'b1;
  logic        ARVALID = 1'b0, ARREADY, RVALID, RREADY = 1'b1;
  logic [63:0] WDATA = '0, RDATA;
  logic [7:0]  WSTRB = '0, exit_code;
  logic [1:0]  BRESP, RRESP;
  logic        success, fail;
  int          checks = 0, failures = 0, cyc = 0;

  axi_dbg_periph #(.IDW(4), .DW(64), .BASE_ADDR(BASE), .UART_DEPTH(8), .UART_DIV(20),
                   .WDOG_CYCLES(1000000)) dut (
    .CLK(CLK), .RST(RST),
    .AWID(AWID), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .success(success), .fail(fail), .exit_code(exit_code)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // k counts negedges from the call; valids go up at iteration aw_dly / w_dly.
  task automatic axi_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           input logic [3:0] id, input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output logic [3:0] bid, output int bk,
                           output int babs);
    bit aw_done = 0, w_done = 0, b_done = 0;
    int k = 0;
    resp = 'x; bid = 'x; bk = -1; babs = -1;
    AWADDR = addr; AWID = id; WDATA = data; WSTRB = strb;
    while (!b_done && k < 200) begin
      @(negedge CLK);
      if (BVALID && aw_done && w_done) begin
        b_done = 1; bk = k; babs = cyc; resp = BRESP; bid = BID;
      end
      if (!aw_done && k >= aw_dly) begin AWVALID = 1'b1; aw_done = AWREADY; end
      else AWVALID = 1'b0;
      if (!w_done && k >= w_dly) begin WVALID = 1'b1; w_done = WREADY; end
      else WVALID = 1'b0;
      k++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    if (!b_done) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=%h got no BVALID within 200 cycles", addr);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, output logic [63:0] data,
                          output logic [1:0] resp, output logic [3:0] rid, output int rk);
    bit ar_done = 0, r_done = 0;
    int k = 0;
    data = 'x; resp = 'x; rid = 'x; rk = -1;
    ARADDR = addr; ARID = id;
    while (!r_done && k < 200) begin
      @(negedge CLK);
      if (RVALID && ar_done) begin
        r_done = 1; rk = k; data = RDATA; resp = RRESP; rid = RID;
      end
      if (!ar_done) begin ARVALID = 1'b1; ar_done = ARREADY; end
      else ARVALID = 1'b0;
      k++;
    end
    ARVALID = 1'b0;
    if (!r_done) begin
      checks++; failures++;
      $display("FAIL read_timeout addr=%h got no RVALID within 200 cycles", addr);
    end
  endtask

  task automatic test_reset();
    logic [63:0] d; logic [1:0] r; logic [3:0] i; int rk;
    repeat (3) @(negedge CLK);
    checks++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin failures++;
      $display("FAIL reset_ready got=%b exp=111", {AWREADY, WREADY, ARREADY}); end
    checks++; if ({BVALID, RVALID} !== 2'b00) begin failures++;
      $display("FAIL reset_valid got=%b exp=00", {BVALID, RVALID}); end
    checks++; if ({success, fail, exit_code} !== 10'd0) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {success, fail, exit_code}); end
    checks++; if ({BID, BRESP, RID, RRESP, RDATA} !== '0) begin failures++;
      $display("FAIL reset_bus_outs got nonzero exp=0"); end
    RST = 1'b0;
    axi_read(A_TMR, 4'h1, d, r, i, rk);
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL reset_timer got=%h exp=0", d); end
    checks++; if (rk !== 1) begin failures++; $display("FAIL read_latency got=%0d exp=1", rk); end
    axi_read(A_SCR, 4'h2, d, r, i, rk);
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL reset_scratch got=%h exp=0", d); end
    checks++; if (i !== 4'h2) begin failures++; $display("FAIL read_rid got=%h exp=2", i); end
    axi_read(A_STAT, 4'h3, d, r, i, rk);
    checks++; if (d !== 64'd0 || r !== 2'b00) begin failures++;
      $display("FAIL reset_status got=%h resp=%b exp=0 resp=00", d, r); end
  endtask

  task automatic test_split_aw_w();
    logic [1:0] r; logic [3:0] b; int bk, babs;
    axi_write(A_UART, 64'h41, 8'h01, 4'h5, 0, 3, r, b, bk, babs);
    checks++; if (bk !== 5) begin failures++; $display("FAIL split_b_latency got=%0d exp=5", bk); end
    checks++; if (b !== 4'h5) begin failures++; $display("FAIL split_bid got=%h exp=5", b); end
    checks++; if (r !== 2'b00) begin failures++; $display("FAIL split_bresp got=%b exp=00", r); end
    repeat (40) @(negedge CLK);
    $display("");
  endtask

  task automatic test_uart_fifo();
    int bks[9]; logic [1:0] rs[9]; logic [3:0] ids[9];
    int nb = 0, idx = 0, k = 0, rk;
    logic [63:0] d; logic [1:0] r; logic [3:0] i;
    axi_read(A_STAT, 4'h4, d, r, i, rk);
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL uart_status_empty got=%h exp=0", d); end
    while (nb < 9 && k < 400) begin
      @(negedge CLK);
      if (BVALID) begin bks[nb] = k; rs[nb] = BRESP; ids[nb] = BID; nb++; end
      if (idx < 9) begin
        AWVALID = 1'b1; WVALID = 1'b1; AWADDR = A_UART; AWID = 4'(idx);
        WDATA = 64'(49 + idx); WSTRB = 8'h01;
        if (AWREADY && WREADY) idx++;
      end else begin
        AWVALID = 1'b0; WVALID = 1'b0;
      end
      k++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    checks++; if (nb !== 9) begin failures++; $display("FAIL uart_b_count got=%0d exp=9", nb); end
    else begin
      checks++; if (bks[0] !== 2) begin failures++; $display("FAIL uart_b0 got=%0d exp=2", bks[0]); end
      checks++; if (bks[7] !== 16) begin failures++; $display("FAIL uart_b7 got=%0d exp=16", bks[7]); end
      checks++; if (bks[8] !== 22) begin failures++; $display("FAIL uart_b8_stall got=%0d exp=22", bks[8]); end
      for (int n = 0; n < 9; n++) begin
        checks++; if (rs[n] !== 2'b00 || ids[n] !== 4'(n)) begin failures++;
          $display("FAIL uart_b%0d resp=%b id=%h exp resp=00 id=%h", n, rs[n], ids[n], 4'(n)); end
      end
    end
    axi_read(A_STAT, 4'h6, d, r, i, rk);
    checks++; if (d !== 64'h88) begin failures++; $display("FAIL uart_status_full got=%h exp=88", d); end
    repeat (200) @(negedge CLK);
    $display("");
    axi_read(A_STAT, 4'h7, d, r, i, rk);
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL uart_status_drained got=%h exp=0", d); end
  endtask

  task automatic test_timer();
    logic [1:0] r; logic [3:0] b, i; logic [63:0] d; int bk, b1, b2, rk;
    axi_write(A_TMR, 64'd1, 8'hFF, 4'h8, 0, 0, r, b, bk, b1);
    axi_read(A_STAT, 4'h8, d, r, i, rk);
    checks++; if (d !== 64'h1) begin failures++; $display("FAIL timer_status_run got=%h exp=1", d); end
    repeat (100) @(negedge CLK);
    axi_write(A_TMR, 64'd0, 8'hFF, 4'h9, 0, 0, r, b, bk, b2);
    repeat (3) @(negedge CLK);
    axi_read(A_TMR, 4'hA, d, r, i, rk);
    checks++; if (d !== 64'(b2 - b1)) begin failures++;
      $display("FAIL timer_count got=%0d exp=%0d", d, b2 - b1); end
    checks++; if (d < 64'd100 || d > 64'd110) begin failures++;
      $display("FAIL timer_range got=%0d exp=100..110", d); end
    checks++; if (r !== 2'b00 || i !== 4'hA) begin failures++;
      $display("FAIL timer_resp got=%b rid=%h exp=00 rid=a", r, i); end
    axi_write(A_TMR, 64'd2, 8'hFF, 4'hB, 0, 0, r, b, bk, b1);
    axi_read(A_TMR, 4'hC, d, r, i, rk);
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL timer_clear got=%0d exp=0", d); end
  endtask

  task automatic test_scratch();
    logic [1:0] r; logic [3:0] b, i; logic [63:0] d; int bk, babs, rk;
    axi_write(A_SCR, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'h3, 0, 0, r, b, bk, babs);
    checks++; if (bk !== 2) begin failures++; $display("FAIL scratch_b_latency got=%0d exp=2", bk); end
    axi_write(A_SCR, 64'd0, 8'h01, 4'h3, 0, 0, r, b, bk, babs);
    axi_read(A_SCR, 4'hD, d, r, i, rk);
    checks++; if (d !== 64'hFFFF_FFFF_FFFF_FF00) begin failures++;
      $display("FAIL scratch_strobe got=%h exp=ffffffffffffff00", d); end
  endtask

  task automatic test_ctrl();
    logic [1:0] r; logic [3:0] b, i; logic [63:0] d; int bk, babs, rk;
    axi_write(A_CTRL, 64'h2A, 8'hFF, 4'h1, 0, 0, r, b, bk, babs);
    checks++; if ({success, fail, exit_code} !== {1'b0, 1'b1, 8'h2A}) begin failures++;
      $display("FAIL ctrl_fail got=%b%b/%h exp=01/2a", success, fail, exit_code); end
    axi_read(A_CTRL, 4'h2, d, r, i, rk);
    checks++; if (d !== 64'hAA) begin failures++; $display("FAIL ctrl_read got=%h exp=aa", d); end
    axi_write(A_CTRL, 64'h1, 8'hFF, 4'h1, 0, 0, r, b, bk, babs);
    checks++; if (r !== 2'b00) begin failures++; $display("FAIL ctrl_late_resp got=%b exp=00", r); end
    checks++; if ({success, fail, exit_code} !== {1'b0, 1'b1, 8'h2A}) begin failures++;
      $display("FAIL ctrl_sticky got=%b%b/%h exp=01/2a", success, fail, exit_code); end
  endtask

  task automatic test_decerr_and_hold();
    logic [1:0] r; logic [3:0] b, i; logic [63:0] d; int bk, babs, rk;
    axi_read(BASE + 32'h30, 4'h6, d, r, i, rk);
    checks++; if (r !== 2'b11 || d !== 64'd0) begin failures++;
      $display("FAIL decerr_read resp=%b data=%h exp resp=11 data=0", r, d); end
    axi_write(32'h1000_0000, 64'h55, 8'hFF, 4'h7, 0, 0, r, b, bk, babs);
    checks++; if (r !== 2'b11 || b !== 4'h7) begin failures++;
      $display("FAIL decerr_write resp=%b id=%h exp resp=11 id=7", r, b); end
    RREADY = 1'b0;
    @(negedge CLK); ARVALID = 1'b1; ARADDR = A_SCR; ARID = 4'h9;
    @(negedge CLK); ARVALID = 1'b0;
    for (int n = 0; n < 5; n++) begin
      checks++; if (!RVALID || RID !== 4'h9 || RDATA !== 64'hFFFF_FFFF_FFFF_FF00 || ARREADY) begin
        failures++; $display("FAIL r_hold%0d vld=%b id=%h data=%h ardy=%b exp 1/9/ffffffffffffff00/0",
                             n, RVALID, RID, RDATA, ARREADY); end
      @(negedge CLK);
    end
    RREADY = 1'b1;
    @(negedge CLK);
    checks++; if (RVALID !== 1'b0) begin failures++; $display("FAIL r_release got=%b exp=0", RVALID); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK); AWVALID = 1'b1; AWADDR = A_SCR; AWID = 4'h2;
    @(negedge CLK); AWVALID = 1'b0;
    checks++; if (AWREADY !== 1'b0) begin failures++; $display("FAIL mid_aw_held got=%b exp=0", AWREADY); end
    #1 RST = 1'b1;
    #1;
    checks++; if (AWREADY !== 1'b1 || fail !== 1'b0 || exit_code !== 8'd0) begin failures++;
      $display("FAIL mid_reset awready=%b fail=%b code=%h exp 1/0/00", AWREADY, fail, exit_code); end
    @(negedge CLK); RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_split_aw_w();
    test_uart_fifo();
    test_timer();
    test_scratch();
    test_ctrl();
    test_decerr_and_hold();
    test_reset_mid();
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
